// File: rtl/prime_pkg.sv
// Shared types and constants for the prime stream sequencer.
package prime_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_DROP,
        WAIT_RDY,
        DRAIN,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_GEN  = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;

endpackage

// File: rtl/stream_fifo.sv
// Registered circular FIFO (no fall-through) used as the output stream buffer.
module stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             has_free
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      used;
    logic             do_push;
    logic             do_pop;

    assign full     = (used == (AW+1)'(DEPTH));
    assign empty    = (used == '0);
    assign has_free = !full;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

endmodule

// File: rtl/prime_stream.sv
// Drives the external prime generator one request at a time and buffers each
// validated prime into a back-pressured valid/ready stream.
module prime_stream
    import prime_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code,
    output logic             gen_go,
    input  logic             gen_ready,
    input  logic             gen_error,
    input  logic [WIDTH-1:0] gen_res,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    state_t           state;
    logic [CW-1:0]    remaining;
    logic [WIDTH-1:0] last_prime;

    logic             fifo_push;
    logic [WIDTH:0]   fifo_push_data;
    logic             fifo_pop;
    logic [WIDTH:0]   fifo_pop_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_has_free;
    logic             final_pop;

    // A result is only accepted when it is error-free and strictly increasing.
    always_comb begin
        fifo_push      = 1'b0;
        fifo_push_data = {remaining == CW'(1), gen_res};
        if (state == WAIT_RDY && gen_ready && !gen_error && gen_res > last_prime && !fifo_full) begin
            fifo_push = 1'b1;
        end
    end

    assign m_valid   = !fifo_empty;
    assign fifo_pop  = m_valid && m_ready;
    assign final_pop = fifo_pop && fifo_pop_data[WIDTH];
    assign m_data    = m_valid ? fifo_pop_data[WIDTH-1:0] : '0;
    assign m_last    = m_valid && fifo_pop_data[WIDTH];

    stream_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .has_free  (fifo_has_free)
    );

    // gen_go defaults low every cycle so each request is a single-cycle pulse,
    // and WAIT_DROP keeps a still-high ready from being mistaken for a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            last_prime <= WIDTH'(1);
            busy       <= 1'b0;
            done       <= 1'b0;
            err_code   <= ERR_NONE;
            gen_go     <= 1'b0;
        end else begin
            gen_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done  <= 1'b1;
                            state <= DRAIN;
                        end else begin
                            done      <= 1'b0;
                            busy      <= 1'b1;
                            remaining <= count;
                            state     <= FIRE;
                        end
                    end
                end
                FIRE: begin
                    if (fifo_has_free && gen_ready) begin
                        gen_go <= 1'b1;
                        state  <= WAIT_DROP;
                    end
                end
                WAIT_DROP: begin
                    if (!gen_ready) begin
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (gen_ready) begin
                        if (gen_error) begin
                            err_code <= ERR_GEN;
                            busy     <= 1'b0;
                            state    <= ERR;
                        end else if (gen_res <= last_prime) begin
                            err_code <= ERR_OVF;
                            busy     <= 1'b0;
                            state    <= ERR;
                        end else begin
                            last_prime <= gen_res;
                            remaining  <= remaining - 1'b1;
                            state      <= (remaining == CW'(1)) ? DRAIN : FIRE;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty || final_pop) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
